// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg : elastic valid/ready pipeline register with a one-entry skid
//                 buffer so in_ready is a flop output; supports flush.
// Revision 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  // State bits are {main_v, skid_v}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         accept;
  logic         drain;

  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits are squashed.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    count = 2'd0;
    case (state_q)
      BUSY:    count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

endmodule

`default_nettype wire
